// File: rtl/sevenseg_pkg.sv
// Shared types, constants and the code-to-segment decoder for the seven-segment driver.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK  = 7'h7F;
    localparam seg_t SEG_DASH   = 7'b0111111;
    localparam seg_t CODE_BLANK = 7'h40;

    // Returns {dp_n, segs_n}; segment order is g..a, all active low.
    function automatic logic [7:0] seg_decode(input seg_t code);
        logic [7:0] r;
        if (code[6]) begin
            r = {1'b1, SEG_BLANK};
        end else if (code[5]) begin
            r = {1'b0, SEG_BLANK};
        end else if (code[4]) begin
            r = {1'b1, SEG_DASH};
        end else begin
            case (code[3:0])
                4'h0:    r = {1'b1, 7'b1000000};
                4'h1:    r = {1'b1, 7'b1111001};
                4'h2:    r = {1'b1, 7'b0100100};
                4'h3:    r = {1'b1, 7'b0110000};
                4'h4:    r = {1'b1, 7'b0011001};
                4'h5:    r = {1'b1, 7'b0010010};
                4'h6:    r = {1'b1, 7'b0000010};
                4'h7:    r = {1'b1, 7'b1111000};
                4'h8:    r = {1'b1, 7'b0000000};
                4'h9:    r = {1'b1, 7'b0010000};
                4'hA:    r = {1'b1, 7'b0001000};
                4'hB:    r = {1'b1, 7'b0000011};
                4'hC:    r = {1'b1, 7'b1000110};
                4'hD:    r = {1'b1, 7'b0100001};
                4'hE:    r = {1'b1, 7'b0000110};
                4'hF:    r = {1'b1, 7'b0001110};
                default: r = {1'b1, SEG_BLANK};
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/sevenseg_mux_n_scan_timer.sv
// Slot/digit/frame counters and blink phase for the multiplexed display scan.
module sevenseg_scan_timer #(
    parameter int NDIGITS      = 8,
    parameter int DIV_COUNT    = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [$clog2(NDIGITS)-1:0] idx,
    output logic                       phase,
    output logic                       slot_end,
    output logic                       frame_end,
    output logic                       blank_window
);
    import sevenseg_pkg::*;

    localparam int IW = $clog2(NDIGITS);
    localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt_r;
    logic [IW-1:0] idx_r;
    logic [FW-1:0] fcnt_r;
    logic          phase_r;

    assign slot_end  = (cnt_r == CW'(DIV_COUNT - 1));
    assign frame_end = slot_end && (idx_r == IW'(NDIGITS - 1));
    assign idx       = idx_r;
    assign phase     = phase_r;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign blank_window = 1'b0;
        end else begin : g_dead
            assign blank_window = (cnt_r < CW'(BLANK_CYCLES));
        end
    endgenerate

    // Slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (slot_end) begin
            cnt_r <= '0;
            if (idx_r == IW'(NDIGITS - 1)) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IW'(1);
            end
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Frame counter; phase flips each time it wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_r  <= '0;
            phase_r <= 1'b0;
        end else if (frame_end) begin
            if (fcnt_r == FW'(BLINK_FRAMES - 1)) begin
                fcnt_r  <= '0;
                phase_r <= ~phase_r;
            end else begin
                fcnt_r  <= fcnt_r + FW'(1);
            end
        end else begin
            fcnt_r  <= fcnt_r;
        end
    end

endmodule

// File: rtl/sevenseg_mux_n.sv
// Multiplexed common-anode seven-segment driver with per-frame capture,
// dead time, blink and leading-zero suppression.
module sevenseg_mux_n #(
    parameter int NDIGITS      = 8,
    parameter int DIV_COUNT    = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [7*NDIGITS-1:0]   data,
    input  logic [NDIGITS-1:0]     blink,
    input  logic                   lzs,
    output logic [NDIGITS-1:0]     an_n,
    output logic [6:0]             segs_n,
    output logic                   dp_n,
    output logic                   frame_done
);
    import sevenseg_pkg::*;

    localparam int IW = $clog2(NDIGITS);

    logic [IW-1:0]             idx_s;
    logic                      phase_s;
    logic                      slot_end_s;
    logic                      frame_end_s;
    logic                      blank_window_s;
    logic                      capture_s;
    logic [NDIGITS-1:0][6:0]   shadow_r;
    logic [NDIGITS-1:0]        lz_s;
    seg_t                      cur_code_s;
    logic                      suppress_s;
    logic                      an_on_s;
    logic [7:0]                dec_s;
    logic [NDIGITS-1:0]        an_n_r;
    seg_t                      segs_n_r;
    logic                      dp_n_r;
    logic                      frame_done_r;

    sevenseg_scan_timer #(
        .NDIGITS      (NDIGITS),
        .DIV_COUNT    (DIV_COUNT),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .idx          (idx_s),
        .phase        (phase_s),
        .slot_end     (slot_end_s),
        .frame_end    (frame_end_s),
        .blank_window (blank_window_s)
    );

    assign capture_s = slot_end_s && frame_end_s;

    // Frame-synchronous capture of the display codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= {NDIGITS{CODE_BLANK}};
        end else if (capture_s) begin
            shadow_r <= data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // A zero is leading while every more-significant digit is zero or blank.
    always_comb begin
        logic clear_above;
        lz_s        = '0;
        clear_above = 1'b1;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            lz_s[i]     = clear_above && (shadow_r[i] == 7'd0);
            clear_above = clear_above && ((shadow_r[i] == 7'd0) || shadow_r[i][6]);
        end
    end

    // Current-digit selection and anode gating.
    always_comb begin
        cur_code_s = shadow_r[idx_s];
        suppress_s = (blink[idx_s] && phase_s) || (lzs && lz_s[idx_s]);
        an_on_s    = enable && !blank_window_s && !suppress_s;
        dec_s      = seg_decode(cur_code_s);
    end

    // Registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n_r       <= '1;
            segs_n_r     <= SEG_BLANK;
            dp_n_r       <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= capture_s;
            if (an_on_s) begin
                an_n_r   <= ~(NDIGITS'(1) << idx_s);
                segs_n_r <= dec_s[6:0];
                dp_n_r   <= dec_s[7];
            end else begin
                an_n_r   <= '1;
                segs_n_r <= SEG_BLANK;
                dp_n_r   <= 1'b1;
            end
        end
    end

    assign an_n       = an_n_r;
    assign segs_n     = segs_n_r;
    assign dp_n       = dp_n_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sevenseg_mux_n.sv
// Randomized self-checking bench for sevenseg_mux_n against a time-based reference model.
module tb_sevenseg_mux_n;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BL    = 1;
    localparam int BF    = 2;
    localparam int FRAME = N * DIV;

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic [7*N-1:0] data;
    logic [N-1:0]   blink;
    logic           lzs;
    logic [N-1:0]   an_n;
    logic [6:0]     segs_n;
    logic           dp_n;
    logic           frame_done;

    int checks   = 0;
    int failures = 0;

    int         t;
    logic [6:0] sh_m [N];
    logic [3:0] exp_an;
    logic [6:0] exp_segs;
    logic       exp_dp;
    logic       exp_fd;

    sevenseg_mux_n #(
        .NDIGITS      (N),
        .DIV_COUNT    (DIV),
        .BLANK_CYCLES (BL),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .data       (data),
        .blink      (blink),
        .lzs        (lzs),
        .an_n       (an_n),
        .segs_n     (segs_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] rand_code();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return 7'(r);
        else if (r == 16) return 7'h20;
        else if (r == 17) return 7'h10;
        else if (r == 18) return 7'(7'h40 | 7'($urandom_range(0, 63)));
        else return 7'($urandom_range(0, 127));
    endfunction

    // Predicts the outputs that follow the next edge from elapsed time, then advances one clock.
    task automatic tick();
        int         idx, cnt, ph;
        logic [6:0] c;
        logic       lz, on;
        idx = (t / DIV) % N;
        cnt = t % DIV;
        ph  = (t / (FRAME * BF)) % 2;
        c   = sh_m[idx];
        lz  = 1'b0;
        if (lzs && idx > 0 && c == 7'd0) begin
            lz = 1'b1;
            for (int j = idx + 1; j < N; j++)
                if (!(sh_m[j] == 7'd0 || sh_m[j][6])) lz = 1'b0;
        end
        on = enable && (cnt >= BL) && !(blink[idx] && ph == 1) && !lz;
        if (!on)        begin exp_an = 4'hF; exp_segs = 7'h7F; exp_dp = 1'b1; end
        else begin
            exp_an = ~(4'b0001 << idx);
            if (c[6])      begin exp_segs = 7'h7F;        exp_dp = 1'b1; end
            else if (c[5]) begin exp_segs = 7'h7F;        exp_dp = 1'b0; end
            else if (c[4]) begin exp_segs = 7'b0111111;   exp_dp = 1'b1; end
            else           begin exp_segs = FONT[c[3:0]]; exp_dp = 1'b1; end
        end
        exp_fd = (t % FRAME == FRAME - 1);
        if (exp_fd)
            for (int i = 0; i < N; i++) sh_m[i] = data[7*i +: 7];
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({an_n, segs_n, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got an=%b segs=%b dp=%b fd=%b want an=1111 segs=1111111 dp=1 fd=0",
                     an_n, segs_n, dp_n, frame_done);
        end
        @(posedge clk);
        #1;
        t = 0;
        for (int i = 0; i < N; i++) sh_m[i] = 7'h40;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int first_fd;
        enable = 1'b1; blink = '0; lzs = 1'b0; data = '0;
        do_reset();
        first_fd = -1;
        for (int k = 1; k <= FRAME; k++) begin
            tick();
            checks++;
            if ({an_n, segs_n, dp_n, frame_done} !== {exp_an, exp_segs, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL reset_frame t=%0d got %b_%b_%b_%b want %b_%b_%b_%b", t,
                         an_n, segs_n, dp_n, frame_done, exp_an, exp_segs, exp_dp, exp_fd);
            end
            if (frame_done && first_fd < 0) first_fd = k;
        end
        checks++;
        if (first_fd != FRAME) begin
            failures++;
            $display("FAIL first_frame_done got clk %0d want clk %0d", first_fd, FRAME);
        end
    endtask

    task automatic test_digits();
        data = {7'd3, 7'd2, 7'd1, 7'd0};
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            checks++;
            if ({an_n, segs_n, dp_n, frame_done} !== {exp_an, exp_segs, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL digits t=%0d got %b_%b_%b_%b want %b_%b_%b_%b", t,
                         an_n, segs_n, dp_n, frame_done, exp_an, exp_segs, exp_dp, exp_fd);
            end
            if (t == 2 * FRAME + 1) begin
                checks++;
                if (an_n !== 4'b1111) begin
                    failures++;
                    $display("FAIL dead_time got an=%b want an=1111", an_n);
                end
            end
            if (t >= 2 * FRAME + 2 && t <= 2 * FRAME + 4) begin
                checks++;
                if ({an_n, segs_n} !== {4'b1110, 7'b1000000}) begin
                    failures++;
                    $display("FAIL digit0_zero got an=%b segs=%b want an=1110 segs=1000000", an_n, segs_n);
                end
            end
            if (t == 3 * FRAME) begin
                checks++;
                if ({an_n, segs_n} !== {4'b0111, 7'b0110000}) begin
                    failures++;
                    $display("FAIL digit3_three got an=%b segs=%b want an=0111 segs=0110000", an_n, segs_n);
                end
            end
        end
    endtask

    task automatic test_midframe();
        int when;
        for (int f = 0; f < 4; f++) begin
            when = $urandom_range(1, FRAME - 2);
            for (int k = 0; k < FRAME; k++) begin
                if (k == when)
                    for (int i = 0; i < N; i++) data[7*i +: 7] = 7'($urandom_range(0, 15));
                tick();
                checks++;
                if ({an_n, segs_n, dp_n, frame_done} !== {exp_an, exp_segs, exp_dp, exp_fd}) begin
                    failures++;
                    $display("FAIL midframe t=%0d got %b_%b_%b_%b want %b_%b_%b_%b", t,
                             an_n, segs_n, dp_n, frame_done, exp_an, exp_segs, exp_dp, exp_fd);
                end
            end
        end
    endtask

    task automatic test_codes();
        data = {7'h4F, 7'h10, 7'h20, 7'h05};
        for (int f = 0; f < 7; f++) begin
            if (f >= 2)
                for (int i = 0; i < N; i++) data[7*i +: 7] = rand_code();
            for (int k = 0; k < FRAME; k++) begin
                tick();
                checks++;
                if ({an_n, segs_n, dp_n, frame_done} !== {exp_an, exp_segs, exp_dp, exp_fd}) begin
                    failures++;
                    $display("FAIL codes t=%0d got %b_%b_%b_%b want %b_%b_%b_%b", t,
                             an_n, segs_n, dp_n, frame_done, exp_an, exp_segs, exp_dp, exp_fd);
                end
            end
        end
    endtask

    task automatic test_lzs();
        logic [3:0] lit_seen;
        lzs = 1'b1;
        for (int f = 0; f < 10; f++) begin
            if (f == 0) data = {7'd0, 7'd0, 7'd5, 7'd0};
            else if (f == 2) data = '0;
            else if (f >= 4)
                for (int i = 0; i < N; i++)
                    data[7*i +: 7] = ($urandom_range(0, 2) == 0) ? rand_code() : 7'd0;
            lit_seen = 4'b0000;
            for (int k = 0; k < FRAME; k++) begin
                tick();
                lit_seen = lit_seen | ~an_n;
                checks++;
                if ({an_n, segs_n, dp_n, frame_done} !== {exp_an, exp_segs, exp_dp, exp_fd}) begin
                    failures++;
                    $display("FAIL lzs t=%0d got %b_%b_%b_%b want %b_%b_%b_%b", t,
                             an_n, segs_n, dp_n, frame_done, exp_an, exp_segs, exp_dp, exp_fd);
                end
            end
            if (f == 1 || f == 3) begin
                checks++;
                if (lit_seen !== ((f == 1) ? 4'b0011 : 4'b0001)) begin
                    failures++;
                    $display("FAIL lzs_digits frame=%0d got lit=%b want lit=%b", f, lit_seen,
                             (f == 1) ? 4'b0011 : 4'b0001);
                end
            end
        end
        lzs = 1'b0;
    endtask

    task automatic test_blink();
        data  = {7'h08, 7'h08, 7'h08, 7'h08};
        blink = 4'b0010;
        for (int k = 0; k < 12 * FRAME; k++) begin
            if (k >= 8 * FRAME) blink = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if ({an_n, segs_n, dp_n, frame_done} !== {exp_an, exp_segs, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL blink t=%0d got %b_%b_%b_%b want %b_%b_%b_%b", t,
                         an_n, segs_n, dp_n, frame_done, exp_an, exp_segs, exp_dp, exp_fd);
            end
        end
        blink = '0;
    endtask

    task automatic test_enable();
        int fd_count;
        enable   = 1'b0;
        fd_count = 0;
        for (int k = 0; k < 5 * FRAME; k++) begin
            if (k >= 3 * FRAME) enable = 1'($urandom_range(0, 1));
            tick();
            if (k < 3 * FRAME && frame_done) fd_count++;
            checks++;
            if ({an_n, segs_n, dp_n, frame_done} !== {exp_an, exp_segs, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL enable t=%0d got %b_%b_%b_%b want %b_%b_%b_%b", t,
                         an_n, segs_n, dp_n, frame_done, exp_an, exp_segs, exp_dp, exp_fd);
            end
        end
        checks++;
        if (fd_count != 3) begin
            failures++;
            $display("FAIL enable_frame_done got %0d pulses want 3", fd_count);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        int budget;
        data   = {7'h08, 7'h08, 7'h08, 7'h08};
        budget = 0;
        do begin
            tick();
            budget++;
        end while (exp_an == 4'hF && budget < 4 * FRAME);
        checks++;
        if (an_n !== exp_an || an_n === 4'hF) begin
            failures++;
            $display("FAIL lit_before_reset got an=%b want an=%b (lit)", an_n, exp_an);
        end
        do_reset();
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            checks++;
            if ({an_n, segs_n, dp_n, frame_done} !== {exp_an, exp_segs, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL after_reset t=%0d got %b_%b_%b_%b want %b_%b_%b_%b", t,
                         an_n, segs_n, dp_n, frame_done, exp_an, exp_segs, exp_dp, exp_fd);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        blink  = '0;
        lzs    = 1'b0;
        data   = '0;
        t      = 0;
        #12;
        test_reset();
        test_digits();
        test_midframe();
        test_codes();
        test_lzs();
        test_blink();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
